addroundkey_stream: RTL and testbench

Streaming, parametrised AddRoundKey stage for the AES datapath. It holds an on-chip round-key bank and XORs each incoming state with the key selected by its round index. Valid/ready handshakes on both sides allow the stage to sit between the key-expansion/round-control logic and the SubBytes/ShiftRows pipeline. It supports AES-128/192/256 round counts, key-bank management and error flagging, none of which a plain combinational XOR has.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/ark_out_fifo.sv | 68 ++++++
 rtl/addroundkey_stream.sv | 102 ++++++++++
 tb/tb_addroundkey_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES datapath constants and payload types.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  // Round-key counts (rounds + 1) for each key size
  localparam int AES128_NK = 11;
  localparam int AES192_NK = 13;
  localparam int AES256_NK = 15;

  typedef logic [AES_BLOCK_W-1:0] aes_state_t;

  // Payload carried by the AddRoundKey output buffer at the default width
  typedef struct packed {
    aes_state_t  state;
    logic [3:0]  round;
    logic        err;
  } ark_entry_t;

endpackage
`default_nettype wire

// File: rtl/ark_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ark_out_fifo
// Description : 2-entry output FIFO with a registered push_ready, so there is
//               no combinational path from pop_ready back to push_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ark_out_fifo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             ready_q;
  logic             do_pop;

  assign pop_valid  = (count != 2'd0);
  assign do_pop     = pop_valid & pop_ready;
  assign pop_data   = head;
  assign push_ready = ready_q;

  // Occupancy after this edge; push is already qualified by push_ready upstream
  always_comb begin
    count_nxt = count;
    case ({push, do_pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Storage and registered ready; head is always the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      head    <= '0;
      tail    <= '0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt < 2'd2);
      if (do_pop) begin
        if (count == 2'd2) begin
          head <= tail;
          if (push) tail <= push_data;
        end else if (push) begin
          head <= push_data;
        end
      end else if (push) begin
        if (count == 2'd0) head <= push_data;
        else               tail <= push_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addroundkey_stream.sv
`default_nettype none
// ============================================================================
// Module      : addroundkey_stream
// Description : Streaming AddRoundKey stage with an on-chip round-key bank,
//               write-through key lookup, error flagging and a 2-entry
//               registered-ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module addroundkey_stream
  import aes_pkg::*;
#(
  parameter int DATA_W   = AES_BLOCK_W,
  parameter int NUM_KEYS = AES256_NK,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err
);

  localparam int PAY_W = DATA_W + IDX_W + 1;

  logic [DATA_W-1:0]   key_bank [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_valid;
  logic [NUM_KEYS-1:0] key_valid_nxt;
  logic                wr_in_range;
  logic                rd_in_range;
  logic [DATA_W-1:0]   key_eff;
  logic                key_ok;
  logic                accept;
  logic [PAY_W-1:0]    push_data;
  logic [PAY_W-1:0]    pop_data;

  assign wr_in_range = ({{(32-IDX_W){1'b0}}, key_wr_idx} < NUM_KEYS);
  assign rd_in_range = ({{(32-IDX_W){1'b0}}, in_round}   < NUM_KEYS);
  assign accept      = in_valid & in_ready;

  // Key data needs no reset: a slot is only used once its valid bit is set
  always_ff @(posedge clk) begin
    if (key_wr_en && wr_in_range) key_bank[key_wr_idx] <= key_wr_data;
  end

  // Clear drops every valid bit, but a same-cycle write still sets its own
  always_comb begin
    key_valid_nxt = key_valid;
    if (key_clr) key_valid_nxt = '0;
    if (key_wr_en && wr_in_range) key_valid_nxt[key_wr_idx] = 1'b1;
  end

  // Valid-bit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_valid <= '0;
    else        key_valid <= key_valid_nxt;
  end

  // Key selection: same-cycle write to the requested slot takes priority
  always_comb begin
    key_eff = '0;
    key_ok  = 1'b0;
    if (rd_in_range) begin
      if (key_wr_en && (key_wr_idx == in_round)) begin
        key_eff = key_wr_data;
        key_ok  = 1'b1;
      end else if (key_valid[in_round]) begin
        key_eff = key_bank[in_round];
        key_ok  = 1'b1;
      end
    end
  end

  // A missing key XORs with zero so the state passes through flagged
  assign push_data = {in_state ^ key_eff, in_round, ~key_ok};

  ark_out_fifo #(
    .WIDTH (PAY_W)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_data  (push_data),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign {out_state, out_round, out_err} = pop_data;

endmodule
`default_nettype wire

// File: tb/tb_addroundkey_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_addroundkey_stream
// Description : Self-checking bench for addroundkey_stream (NUM_KEYS = 11).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addroundkey_stream;

  localparam int NK = 11;
  localparam int IW = 4;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_wr_en;
  logic [IW-1:0] key_wr_idx;
  logic [DW-1:0] key_wr_data;
  logic          key_clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_state;
  logic [IW-1:0] in_round;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_state;
  logic [IW-1:0] out_round;
  logic          out_err;

  addroundkey_stream #(
    .DATA_W   (DW),
    .NUM_KEYS (NK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_clr     (key_clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_round    (in_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .out_round   (out_round),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] st;
    logic [IW-1:0] rnd;
    logic          err;
  } exp_t;

  logic [DW-1:0] m_key [16];
  bit            m_val [16];
  exp_t          q[$];
  bit            exp_rdy;
  bit            last_xfer;
  int            vec_cnt = 0;
  int            bad_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check outputs before the edge, then advance the model across the edge
  task automatic step();
    exp_t e;
    bit   xfer;
    bit   pop;
    bit   hit;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_state", out_state, q[0].st);
      chk("out_round", out_round, q[0].rnd);
      chk("out_err", out_err, q[0].err);
    end
    xfer = in_valid && exp_rdy;
    pop  = (q.size() != 0) && out_ready;
    e.rnd = in_round;
    e.st  = in_state;
    e.err = 1'b1;
    if (xfer && in_round < NK) begin
      hit = key_wr_en && key_wr_idx == in_round;
      if (hit) begin
        e.st = in_state ^ key_wr_data; e.err = 1'b0;
      end else if (m_val[in_round]) begin
        e.st = in_state ^ m_key[in_round]; e.err = 1'b0;
      end
    end
    if (pop) void'(q.pop_front());
    if (xfer) q.push_back(e);
    if (key_clr) for (int i = 0; i < 16; i++) m_val[i] = 0;
    if (key_wr_en && key_wr_idx < NK) begin
      m_key[key_wr_idx] = key_wr_data;
      m_val[key_wr_idx] = 1;
    end
    exp_rdy   = q.size() < 2;
    last_xfer = xfer;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    key_wr_en = 0; key_wr_idx = '0; key_wr_data = '0; key_clr = 0;
    in_valid = 0; in_state = '0; in_round = '0;
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit            load;
    bit            pre_clr;
    bit            wt;
    logic [IW-1:0] k_idx;
    logic [DW-1:0] k_data;
    logic [DW-1:0] st;
    logic [IW-1:0] rnd;
    logic [DW-1:0] exp_st;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold_st;
    tbl[0] = '{1, 0, 0, 4'd0, 128'hdc9037b0_9b49dfe9_97fe723f_388115a7,
               128'hb9e447c5_948e20d6_57169af5_75513f3b, 4'd0,
               128'h65747075_0fc7ff3f_c0e8e8ca_4dd02a9c, 1'b0};
    tbl[1] = '{0, 0, 0, 4'd0, '0,
               128'h01234567_89abcdef_fedcba98_76543210, 4'd14,
               128'h01234567_89abcdef_fedcba98_76543210, 1'b1};
    tbl[2] = '{0, 0, 1, 4'd3, {128{1'b1}}, '0, 4'd3, {128{1'b1}}, 1'b0};
    tbl[3] = '{0, 0, 0, 4'd0, '0, 128'hcafef00d_00000000_11111111_deadbeef, 4'd5,
               128'hcafef00d_00000000_11111111_deadbeef, 1'b1};
    tbl[4] = '{1, 0, 0, 4'd10, {16{8'h0f}}, {8{16'h00ff}}, 4'd10, {4{32'h0ff00ff0}}, 1'b0};
    tbl[5] = '{0, 1, 0, 4'd0, '0, 128'h12345678_12345678_12345678_12345678, 4'd0,
               128'h12345678_12345678_12345678_12345678, 1'b1};

    for (int i = 0; i < 16; i++) begin m_val[i] = 0; m_key[i] = '0; end
    idle_inputs();
    out_ready = 0;
    rst_n = 0;
    exp_rdy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, '0);
    chk("rst_out_round", out_round, '0);
    chk("rst_out_err", out_err, 0);
    rst_n = 1;
    step();

    // Directed single transactions
    foreach (tbl[i]) begin
      if (tbl[i].load) begin
        key_wr_en = 1; key_wr_idx = tbl[i].k_idx; key_wr_data = tbl[i].k_data;
        step();
        idle_inputs();
      end
      if (tbl[i].pre_clr) begin
        key_clr = 1; step(); key_clr = 0;
      end
      out_ready = 1;
      in_valid = 1; in_state = tbl[i].st; in_round = tbl[i].rnd;
      if (tbl[i].wt) begin
        key_wr_en = 1; key_wr_idx = tbl[i].k_idx; key_wr_data = tbl[i].k_data;
      end
      step();
      idle_inputs();
      chk("tbl_state", out_state, tbl[i].exp_st);
      chk("tbl_err", out_err, tbl[i].exp_err);
      chk("tbl_round", out_round, tbl[i].rnd);
      step();
    end

    // Back-to-back stream over rounds 0..10
    for (int r = 0; r < NK; r++) begin
      key_wr_en = 1; key_wr_idx = IW'(r); key_wr_data = {16{8'(r)}};
      step();
    end
    idle_inputs();
    out_ready = 1;
    for (int r = 0; r < NK; r++) begin
      in_valid = 1; in_state = '0; in_round = IW'(r);
      step();
      chk("stream_out", out_state, {16{8'(r)}});
    end
    idle_inputs();
    repeat (2) step();

    // Backpressure: three offers, two land, third waits for a pop
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_state = rand128(); in_round = IW'(k);
      step();
    end
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    for (int k = 0; k < 10 && in_valid; k++) begin
      step();
      if (last_xfer) in_valid = 0;
    end
    chk("bp_third_taken", in_valid, 0);
    idle_inputs();
    repeat (3) step();

    // Asynchronous reset with two entries buffered
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_state = rand128(); in_round = IW'(k);
      step();
    end
    idle_inputs();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_state", out_state, '0);
    q.delete();
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    exp_rdy = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (3) step();

    // Randomized traffic against the model
    last_xfer = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !last_xfer)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_state = rand128();
        in_round = IW'($urandom_range(0, 15));
      end
      key_wr_en   = ($urandom_range(0, 9) < 3);
      key_wr_idx  = ($urandom_range(0, 3) == 0) ? in_round : IW'($urandom_range(0, 15));
      key_wr_data = rand128();
      key_clr     = ($urandom_range(0, 31) == 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      step();
    end
    idle_inputs();
    out_ready = 1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
